// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: action indices, PS/2 scan codes and the
// scan-code to one-hot action decoder used by the key event queue.
package kbd_pkg;

  localparam int NUM_ACTIONS = 9;

  localparam int ACT_L     = 0;
  localparam int ACT_R     = 1;
  localparam int ACT_U     = 2;
  localparam int ACT_D     = 3;
  localparam int ACT_PLACE = 4;
  localparam int ACT_ROT   = 5;
  localparam int ACT_SEL1  = 6;
  localparam int ACT_SEL2  = 7;
  localparam int ACT_SEL3  = 8;

  // Two codes map to each movement action (arrow key and letter key)
  localparam logic [7:0] SC_L_ARROW = 8'h6B;
  localparam logic [7:0] SC_L_ALT   = 8'h1C;
  localparam logic [7:0] SC_R_ARROW = 8'h74;
  localparam logic [7:0] SC_R_ALT   = 8'h23;
  localparam logic [7:0] SC_U_ARROW = 8'h75;
  localparam logic [7:0] SC_U_ALT   = 8'h1D;
  localparam logic [7:0] SC_D_ARROW = 8'h72;
  localparam logic [7:0] SC_D_ALT   = 8'h1B;
  localparam logic [7:0] SC_PLACE   = 8'h29;
  localparam logic [7:0] SC_ROT     = 8'h2D;
  localparam logic [7:0] SC_SEL1    = 8'h16;
  localparam logic [7:0] SC_SEL2    = 8'h1E;
  localparam logic [7:0] SC_SEL3    = 8'h26;

  typedef logic [NUM_ACTIONS-1:0] action_t;

  typedef struct packed {
    logic    valid;
    action_t onehot;
  } decode_t;

  // Auto-repeat phase of a held key: waiting for the initial delay, then periodic
  typedef enum logic {
    PH_FIRST,
    PH_PERIODIC
  } rep_phase_t;

  function automatic decode_t scan_to_action(input logic [7:0] code);
    decode_t d;
    d.valid  = 1'b1;
    d.onehot = '0;
    case (code)
      SC_L_ARROW, SC_L_ALT: d.onehot[ACT_L]     = 1'b1;
      SC_R_ARROW, SC_R_ALT: d.onehot[ACT_R]     = 1'b1;
      SC_U_ARROW, SC_U_ALT: d.onehot[ACT_U]     = 1'b1;
      SC_D_ARROW, SC_D_ALT: d.onehot[ACT_D]     = 1'b1;
      SC_PLACE:             d.onehot[ACT_PLACE] = 1'b1;
      SC_ROT:               d.onehot[ACT_ROT]   = 1'b1;
      SC_SEL1:              d.onehot[ACT_SEL1]  = 1'b1;
      SC_SEL2:              d.onehot[ACT_SEL2]  = 1'b1;
      SC_SEL3:              d.onehot[ACT_SEL3]  = 1'b1;
      default:              d.valid             = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Bundle of the key event queue's keyboard inputs and game-side outputs.
interface key_event_queue_if
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    scan_code;
  logic          make_pulse;
  logic          break_pulse;
  logic          tick_en;
  logic          flush;
  logic          ev_valid;
  action_t       ev_action;
  action_t       held;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          any_key;

  modport master (
    output scan_code, make_pulse, break_pulse, tick_en, flush,
    input  ev_valid, ev_action, held, fifo_count, overflow, any_key
  );

  modport slave (
    input  scan_code, make_pulse, break_pulse, tick_en, flush,
    output ev_valid, ev_action, held, fifo_count, overflow, any_key
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. A push while full is only taken
// when a pop frees a slot in the same cycle; drop policy belongs to the caller.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/key_event_queue.sv
// Keyboard event path: decodes make/break codes to one-hot actions, tracks
// held keys, generates auto-repeat per action on game ticks, queues events
// and releases at most one event per game tick.
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int      DEPTH        = 8,
  parameter int      REPEAT_DELAY = 15,
  parameter int      REPEAT_RATE  = 4,
  parameter action_t REPEAT_MASK  = 9'h00F,
  parameter int      CNT_W        = 6
) (
  input logic               clk,
  input logic               reset,
  key_event_queue_if.slave  kbd
);
  localparam int CW = $clog2(DEPTH) + 1;

  decode_t          dec;
  logic             new_make;
  logic             do_break;
  logic             push_req;
  logic             pop_ok;
  action_t          grant;
  action_t          push_data;
  action_t          fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  action_t          held_q,    held_d;
  action_t          pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q   [NUM_ACTIONS];
  logic [CNT_W-1:0] cnt_d   [NUM_ACTIONS];
  rep_phase_t       phase_q [NUM_ACTIONS];
  rep_phase_t       phase_d [NUM_ACTIONS];
  logic             ev_valid_q;
  action_t          ev_action_q;
  logic             any_key_q;
  logic             overflow_q;

  assign dec      = scan_to_action(kbd.scan_code);
  // Host typematic makes of an already-held action produce nothing
  assign new_make = kbd.make_pulse & dec.valid & ~|(dec.onehot & held_q);
  assign do_break = kbd.break_pulse & dec.valid;
  // Lowest-index pending repeat
  assign grant     = pending_q & (~pending_q + action_t'(1));
  assign push_req  = (new_make | (|pending_q)) & ~kbd.flush;
  assign push_data = new_make ? dec.onehot : grant;
  assign pop_ok    = kbd.tick_en & ~fifo_empty & ~kbd.flush;

  // Held-key tracking, repeat counters and pending-repeat bookkeeping
  always_comb begin
    held_d    = held_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    // A fresh make owns the push slot, so the granted repeat stays pending
    if (!new_make) pending_d = pending_q & ~grant;
    for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
      if (kbd.tick_en && held_q[a] && REPEAT_MASK[a]) begin
        if (phase_q[a] == PH_FIRST &&
            (cnt_q[a] + CNT_W'(1)) == CNT_W'(REPEAT_DELAY)) begin
          pending_d[a] = 1'b1;
          cnt_d[a]     = '0;
          phase_d[a]   = PH_PERIODIC;
        end else if (phase_q[a] == PH_PERIODIC &&
                     (cnt_q[a] + CNT_W'(1)) == CNT_W'(REPEAT_RATE)) begin
          pending_d[a] = 1'b1;
          cnt_d[a]     = '0;
        end else begin
          cnt_d[a] = cnt_q[a] + CNT_W'(1);
        end
      end
      if (do_break && dec.onehot[a]) begin
        held_d[a]    = 1'b0;
        cnt_d[a]     = '0;
        pending_d[a] = 1'b0;
      end
      if (new_make && dec.onehot[a]) begin
        held_d[a]  = 1'b1;
        cnt_d[a]   = '0;
        phase_d[a] = PH_FIRST;
      end
    end
    if (kbd.flush) pending_d = '0;
  end

  // State registers and registered event outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q      <= '0;
      pending_q   <= '0;
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
        cnt_q[a]   <= '0;
        phase_q[a] <= PH_FIRST;
      end
      ev_valid_q  <= 1'b0;
      ev_action_q <= '0;
      any_key_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      held_q      <= held_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      ev_valid_q  <= pop_ok;
      ev_action_q <= pop_ok ? fifo_head : '0;
      any_key_q   <= new_make;
      overflow_q  <= overflow_q | (push_req & fifo_full & ~pop_ok);
    end
  end

  sync_fifo #(
    .WIDTH (NUM_ACTIONS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push_req),
    .pop_i   (kbd.tick_en),
    .flush_i (kbd.flush),
    .wdata_i (push_data),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kbd.ev_valid   = ev_valid_q;
  assign kbd.ev_action  = ev_action_q;
  assign kbd.held       = held_q;
  assign kbd.fifo_count = fifo_count;
  assign kbd.overflow   = overflow_q;
  assign kbd.any_key    = any_key_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against a queue-based
// reference model of the event path.
module tb_key_event_queue;
  localparam int            DEPTH = 8;
  localparam int            DLY   = 3;
  localparam int            RATE  = 2;
  localparam logic [8:0]    MASK  = 9'h00F;

  logic clk = 1'b0;
  logic reset;

  key_event_queue_if #(.DEPTH(DEPTH)) kbd_if ();

  key_event_queue #(
    .DEPTH        (DEPTH),
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RATE),
    .REPEAT_MASK  (MASK),
    .CNT_W        (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kbd   (kbd_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit         m_held [9];
  int         m_cnt  [9];
  bit         m_per  [9];
  bit         m_pend [9];
  logic [8:0] m_q [$];
  bit         m_ovf, m_evv, m_any;
  logic [8:0] m_eva;
  logic [8:0] ev_log [$];

  function automatic int act_of(input logic [7:0] c);
    case (c)
      8'h6B, 8'h1C: return 0;
      8'h74, 8'h23: return 1;
      8'h75, 8'h1D: return 2;
      8'h72, 8'h1B: return 3;
      8'h29:        return 4;
      8'h2D:        return 5;
      8'h16:        return 6;
      8'h1E:        return 7;
      8'h26:        return 8;
      default:      return -1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) begin
      m_held[i] = 0; m_cnt[i] = 0; m_per[i] = 0; m_pend[i] = 0;
    end
    m_q.delete();
    m_ovf = 0; m_evv = 0; m_any = 0; m_eva = '0;
  endtask

  task automatic model_step(input bit mk, input bit brk, input logic [7:0] code,
                            input bit tick, input bit fl);
    int         idx;
    bit         nm;
    bit         have_push;
    bit         found;
    logic [8:0] pv;
    idx       = act_of(code);
    nm        = mk && idx >= 0 && !m_held[(idx < 0) ? 0 : idx];
    have_push = 0;
    found     = 0;
    pv        = '0;
    if (nm) begin
      have_push = 1;
      pv[idx]   = 1'b1;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (!found && m_pend[i]) begin
          found = 1; have_push = 1; pv[i] = 1'b1; m_pend[i] = 0;
        end
      end
    end
    if (tick) begin
      for (int i = 0; i < 9; i++) begin
        if (m_held[i] && MASK[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == (m_per[i] ? RATE : DLY)) begin
            m_pend[i] = 1; m_cnt[i] = 0; m_per[i] = 1;
          end
        end
      end
    end
    if (brk && idx >= 0) begin
      m_held[idx] = 0; m_cnt[idx] = 0; m_pend[idx] = 0;
    end
    if (nm) begin
      m_held[idx] = 1; m_cnt[idx] = 0; m_per[idx] = 0;
    end
    m_any = nm;
    if (fl) begin
      m_q.delete();
      for (int i = 0; i < 9; i++) m_pend[i] = 0;
      m_evv = 0; m_eva = '0;
    end else begin
      if (tick && m_q.size() > 0) begin
        m_evv = 1; m_eva = m_q.pop_front();
      end else begin
        m_evv = 0; m_eva = '0;
      end
      if (have_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pv);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [8:0] h;
    for (int i = 0; i < 9; i++) h[i] = m_held[i];
    chk({tag, ".ev_valid"},   kbd_if.ev_valid,   m_evv);
    chk({tag, ".ev_action"},  kbd_if.ev_action,  m_eva);
    chk({tag, ".held"},       kbd_if.held,       h);
    chk({tag, ".fifo_count"}, kbd_if.fifo_count, m_q.size());
    chk({tag, ".overflow"},   kbd_if.overflow,   m_ovf);
    chk({tag, ".any_key"},    kbd_if.any_key,    m_any);
  endtask

  task automatic step(input bit mk, input bit brk, input logic [7:0] code,
                      input bit tick, input bit fl, input string tag);
    kbd_if.make_pulse  = mk;
    kbd_if.break_pulse = brk;
    kbd_if.scan_code   = code;
    kbd_if.tick_en     = tick;
    kbd_if.flush       = fl;
    model_step(mk, brk, code, tick, fl);
    @(posedge clk);
    #1;
    kbd_if.make_pulse  = 0;
    kbd_if.break_pulse = 0;
    kbd_if.scan_code   = 8'h00;
    kbd_if.tick_en     = 0;
    kbd_if.flush       = 0;
    compare_all(tag);
    if (kbd_if.ev_valid) ev_log.push_back(kbd_if.ev_action);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, "idle");
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 1, 0, "tick");
  endtask

  task automatic apply_reset();
    reset = 1;
    #2;
    model_clear();
    compare_all("reset_async");
    @(posedge clk);
    #1;
    reset = 0;
    compare_all("reset_rel");
    ev_log.delete();
  endtask

  logic [7:0] codes [16] = '{8'h6B, 8'h1C, 8'h74, 8'h23, 8'h75, 8'h1D, 8'h72, 8'h1B,
                             8'h29, 8'h2D, 8'h16, 8'h1E, 8'h26, 8'h00, 8'hF0, 8'h5A};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    kbd_if.scan_code   = 8'h00;
    kbd_if.make_pulse  = 0;
    kbd_if.break_pulse = 0;
    kbd_if.tick_en     = 0;
    kbd_if.flush       = 0;
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    compare_all("por");
    chk("por_count", kbd_if.fifo_count, 0);

    // Single event with hold and release
    step(1, 0, 8'h6B, 0, 0, "t2_make");
    chk("t2_count", kbd_if.fifo_count, 1);
    chk("t2_anykey", kbd_if.any_key, 1);
    idle(4);
    step(0, 0, 8'h00, 1, 0, "t2_tick");
    chk("t2_evv", kbd_if.ev_valid, 1);
    chk("t2_eva", kbd_if.ev_action, 9'h001);
    chk("t2_held", kbd_if.held, 9'h001);
    idle(1);
    chk("t2_evv_once", kbd_if.ev_valid, 0);
    step(0, 1, 8'h6B, 0, 0, "t2_break");
    chk("t2_held_rel", kbd_if.held, 9'h000);

    // Reset mid-stream with three queued events
    apply_reset();
    step(1, 0, 8'h29, 0, 0, "t1"); step(0, 1, 8'h29, 0, 0, "t1");
    step(1, 0, 8'h2D, 0, 0, "t1"); step(0, 1, 8'h2D, 0, 0, "t1");
    step(1, 0, 8'h26, 0, 0, "t1");
    chk("t1_count3", kbd_if.fifo_count, 3);
    reset = 1;
    #2;
    chk("t1_count0", kbd_if.fifo_count, 0);
    chk("t1_held0", kbd_if.held, 0);
    chk("t1_evv0", kbd_if.ev_valid, 0);
    chk("t1_ovf0", kbd_if.overflow, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    step(0, 0, 8'h00, 1, 0, "t1_tick");
    chk("t1_no_ev", kbd_if.ev_valid, 0);

    // Overflow
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 8'h29, 0, 0, "t3_make");
      step(0, 1, 8'h29, 0, 0, "t3_break");
    end
    chk("t3_count", kbd_if.fifo_count, 8);
    chk("t3_ovf", kbd_if.overflow, 1);
    ev_log.delete();
    tick(9);
    chk("t3_nev", ev_log.size(), 8);
    foreach (ev_log[i]) chk("t3_eva", ev_log[i], 9'h010);
    chk("t3_ovf_sticky", kbd_if.overflow, 1);

    // Auto-repeat, held through nine ticks
    apply_reset();
    step(1, 0, 8'h74, 0, 0, "t4_make");
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 8'h00, 1, 0, "t4_tick");
      idle(3);
    end
    step(0, 1, 8'h74, 0, 0, "t4_break");
    for (int i = 0; i < 4; i++) begin step(0, 0, 8'h00, 1, 0, "t4_drain"); idle(1); end
    chk("t4_nev", ev_log.size(), 5);
    foreach (ev_log[i]) chk("t4_eva", ev_log[i], 9'h002);

    // Auto-repeat, released after tick 4
    apply_reset();
    step(1, 0, 8'h74, 0, 0, "t4b_make");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 0, "t4b_tick");
      idle(3);
    end
    step(0, 1, 8'h74, 0, 0, "t4b_break");
    for (int i = 0; i < 4; i++) begin step(0, 0, 8'h00, 1, 0, "t4b_drain"); idle(1); end
    chk("t4b_nev", ev_log.size(), 2);

    // Make collides with a maturing repeat; then host typematic
    apply_reset();
    step(1, 0, 8'h6B, 0, 0, "t5_makeL");
    tick(2);
    step(1, 0, 8'h2D, 1, 0, "t5_rot_and_tick");
    chk("t5_count_rot", kbd_if.fifo_count, 1);
    idle(1);
    chk("t5_count_both", kbd_if.fifo_count, 2);
    chk("t5_held", kbd_if.held, 9'h021);
    ev_log.delete();
    tick(2);
    chk("t5_nev", ev_log.size(), 2);
    if (ev_log.size() >= 2) begin
      chk("t5_first", ev_log[0], 9'h020);
      chk("t5_second", ev_log[1], 9'h001);
    end
    idle(1);
    chk("t5_count_pre", kbd_if.fifo_count, 1);
    step(1, 0, 8'h2D, 0, 0, "t5_typematic");
    chk("t5_count_typ", kbd_if.fifo_count, 1);
    chk("t5_anykey_typ", kbd_if.any_key, 0);
    step(0, 1, 8'h6B, 0, 0, "t5_brkL");
    step(0, 1, 8'h2D, 0, 0, "t5_brkR");

    // Flush against simultaneous make and tick
    apply_reset();
    step(1, 0, 8'h29, 0, 0, "t6"); step(0, 1, 8'h29, 0, 0, "t6");
    step(1, 0, 8'h2D, 0, 0, "t6"); step(0, 1, 8'h2D, 0, 0, "t6");
    step(1, 0, 8'h26, 0, 0, "t6"); step(0, 1, 8'h26, 0, 0, "t6");
    chk("t6_count3", kbd_if.fifo_count, 3);
    step(1, 0, 8'h16, 1, 1, "t6_flush");
    chk("t6_count0", kbd_if.fifo_count, 0);
    chk("t6_no_ev", kbd_if.ev_valid, 0);
    chk("t6_held6", kbd_if.held, 9'h040);
    idle(1);
    chk("t6_count_after", kbd_if.fifo_count, 0);

    // Randomized traffic
    apply_reset();
    for (int n = 0; n < 2500; n++) begin
      int  r;
      bit  mk, brk, tk, fl;
      logic [7:0] c;
      r   = $urandom_range(0, 99);
      mk  = (r < 12);
      brk = (r >= 12 && r < 22);
      c   = codes[$urandom_range(0, 15)];
      tk  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 127) == 0);
      step(mk, brk, c, tk, fl, "rnd");
      if (n == 1200) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
